// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback requester and register-file write port bundle
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        WE3;
    logic [4:0]  WA3;
    logic [31:0] WD3;
    logic        busy;
    logic        grant_id;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  WE3, WA3, WD3, busy, grant_id
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output WE3, WA3, WD3, busy, grant_id
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester round-robin writeback arbiter with post-reset register clear
module rf_wb_arbiter #(
    parameter bit CLR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    rf_wb_arbiter_if.slave wb
);
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam state_t RST_STATE = CLR_EN ? CLEAR : RUN;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic        last_b;
    logic        a_rdy;
    logic        b_rdy;
    logic        busy_c;
    logic        we_q;
    logic [4:0]  wa_q;
    logic [31:0] wd_q;
    logic        gid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && cnt == 5'd31) begin
            state_nxt = RUN;
        end
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        busy_c = 1'b0;
        a_rdy  = 1'b0;
        b_rdy  = 1'b0;
        if (state == CLEAR) begin
            busy_c = 1'b1;
        end else begin
            a_rdy = wb.a_valid && (!wb.b_valid || last_b);
            b_rdy = wb.b_valid && (!wb.a_valid || !last_b);
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 5'd1;
            last_b <= 1'b1;
            we_q   <= 1'b0;
            wa_q   <= 5'd0;
            wd_q   <= 32'd0;
            gid_q  <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            wa_q  <= 5'd0;
            wd_q  <= 32'd0;
            gid_q <= 1'b0;
            if (state == CLEAR) begin
                we_q <= 1'b1;
                wa_q <= cnt;
                cnt  <= cnt + 5'd1;
            end else if (a_rdy) begin
                we_q   <= |wb.a_addr;
                wa_q   <= wb.a_addr;
                wd_q   <= (|wb.a_addr) ? wb.a_data : 32'd0;
                last_b <= 1'b0;
            end else if (b_rdy) begin
                we_q   <= |wb.b_addr;
                wa_q   <= wb.b_addr;
                wd_q   <= (|wb.b_addr) ? wb.b_data : 32'd0;
                gid_q  <= 1'b1;
                last_b <= 1'b1;
            end
        end
    end

    assign wb.a_ready  = a_rdy;
    assign wb.b_ready  = b_rdy;
    assign wb.busy     = busy_c;
    assign wb.WE3      = we_q;
    assign wb.WA3      = wa_q;
    assign wb.WD3      = wd_q;
    assign wb.grant_id = gid_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    logic clk;
    logic reset;

    rf_wb_arbiter_if wb0 ();
    rf_wb_arbiter_if wb1 ();

    rf_wb_arbiter #(.CLR_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .wb(wb0.slave));
    rf_wb_arbiter #(.CLR_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .wb(wb1.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gid;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 0;
    int          busy1_seen = 0;
    logic [31:0] dut_rf [32];

    // Reference model: remaining clear writes, who won last, and whether reset has been seen.
    int          m_clear_left = 0;
    bit          m_last_b = 1;
    bit          m_known = 0;

    bit          ga, gb;
    bit          pa_v, pb_v;
    logic [4:0]  pa_a, pb_a;
    logic [31:0] pa_d, pb_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst,
                         input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                         output bit a_g, output bit b_g);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        wb0.a_valid = av; wb0.a_addr = aa; wb0.a_data = ad;
        wb0.b_valid = bv; wb0.b_addr = ba; wb0.b_data = bd;
        wb1.a_valid = av; wb1.a_addr = aa; wb1.a_data = ad;
        wb1.b_valid = bv; wb1.b_addr = ba; wb1.b_data = bd;
        @(negedge clk);
        e = '{we: 1'b0, wa: 5'd0, wd: 32'd0, gid: 1'b0};
        a_g = 0;
        b_g = 0;
        if (m_known) begin
            if (m_clear_left == 0) begin
                if (av && bv) begin
                    a_g = m_last_b;
                    b_g = !m_last_b;
                end else begin
                    a_g = av;
                    b_g = bv;
                end
            end
            chk("busy", wb0.busy, (m_clear_left > 0));
            chk("a_ready", wb0.a_ready, a_g);
            chk("b_ready", wb0.b_ready, b_g);
        end
        if (rst) begin
            m_clear_left = 31;
            m_last_b = 1;
            m_known = 1;
            a_g = 0;
            b_g = 0;
        end else if (m_known && m_clear_left > 0) begin
            e.we = 1'b1;
            e.wa = 5'(32 - m_clear_left);
            m_clear_left--;
        end else if (a_g) begin
            e.we = (aa != 0);
            e.wa = aa;
            e.wd = (aa != 0) ? ad : 32'd0;
            m_last_b = 0;
        end else if (b_g) begin
            e.we = (ba != 0);
            e.wa = ba;
            e.wd = (ba != 0) ? bd : 32'd0;
            e.gid = 1'b1;
            m_last_b = 1;
        end
        exp_q.push_back(e);
        mon_en = 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL queue_underrun: no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("WE3", wb0.WE3, e.we);
                    chk("WA3", wb0.WA3, e.wa);
                    chk("WD3", wb0.WD3, e.wd);
                    chk("grant_id", wb0.grant_id, e.gid);
                    if (wb0.WE3 === 1'b1) dut_rf[wb0.WA3] = wb0.WD3;
                end
                if (wb1.busy === 1'b1) busy1_seen++;
            end
        end
    end

    initial begin
        clk = 0;
        reset = 1;
        wb0.a_valid = 0; wb0.a_addr = 0; wb0.a_data = 0;
        wb0.b_valid = 0; wb0.b_addr = 0; wb0.b_data = 0;
        wb1.a_valid = 0; wb1.a_addr = 0; wb1.a_data = 0;
        wb1.b_valid = 0; wb1.b_addr = 0; wb1.b_data = 0;
        for (int i = 0; i < 32; i++) dut_rf[i] = 32'd0;

        cycle(1, 0, 0, 0, 0, 0, 0, ga, gb);
        cycle(1, 0, 0, 0, 0, 0, 0, ga, gb);

        // A holds a request through the clear; the CLR_EN=0 instance takes it at once.
        cycle(0, 1, 5'd3, 32'h1234_5678, 0, 0, 0, ga, gb);
        chk("nclr_a_ready", wb1.a_ready, 1);
        chk("nclr_busy", wb1.busy, 0);
        cycle(0, 1, 5'd3, 32'h1234_5678, 0, 0, 0, ga, gb);
        chk("nclr_WE3", wb1.WE3, 1);
        chk("nclr_WA3", wb1.WA3, 3);
        chk("nclr_WD3", wb1.WD3, 32'h1234_5678);
        for (int i = 0; i < 9; i++) cycle(0, 1, 5'd3, 32'h1234_5678, 0, 0, 0, ga, gb);

        // Eleven clear writes done (cnt now 12): reset mid-clear, then the full sequence.
        cycle(1, 1, 5'd3, 32'h1234_5678, 0, 0, 0, ga, gb);
        for (int i = 0; i < 31; i++) cycle(0, 1, 5'd3, 32'h1234_5678, 0, 0, 0, ga, gb);

        for (int i = 0; i < 4; i++) cycle(0, 1, 5'd5, 32'hAAAA_0000, 1, 5'd6, 32'hBBBB_0000, ga, gb);
        cycle(0, 0, 0, 0, 0, 0, 0, ga, gb);

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 5'd7, 32'h0000_7777, ga, gb);

        cycle(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, ga, gb);

        cycle(0, 0, 0, 0, 1, 5'd10, 32'h0000_00AA, ga, gb);
        cycle(0, 1, 5'd9, 32'd1, 1, 5'd9, 32'd2, ga, gb);
        cycle(0, 0, 0, 0, 1, 5'd9, 32'd2, ga, gb);
        cycle(0, 0, 0, 0, 0, 0, 0, ga, gb);
        cycle(0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("rf9_final", dut_rf[9], 32'd2);

        pa_v = 0; pb_v = 0;
        pa_a = 0; pb_a = 0;
        pa_d = 0; pb_d = 0;
        for (int i = 0; i < 400; i++) begin
            bit rst;
            rst = ($urandom_range(0, 149) == 0);
            if (!pa_v && $urandom_range(0, 2) != 0) begin
                pa_v = 1;
                pa_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pa_d = $urandom;
            end
            if (!pb_v && $urandom_range(0, 2) != 0) begin
                pb_v = 1;
                pb_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pb_d = $urandom;
            end
            cycle(rst, pa_v, pa_a, pa_d, pb_v, pb_a, pb_d, ga, gb);
            if (ga) pa_v = 0;
            if (gb) pb_v = 0;
        end

        cycle(0, 0, 0, 0, 0, 0, 0, ga, gb);
        @(posedge clk);
        #3;
        chk("queue_drain", exp_q.size(), 0);
        chk("nclr_busy_never", busy1_seen, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter CLR_EN, default 1: 1 enables the post-reset register-clear sequence, 0 skips it.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-005 a_ready  output  1  requester A write accepted this cycle.
REQ-006 a_addr  input  5  requester A destination register.
REQ-007 a_data  input  32  requester A write data.
REQ-008 b_valid  input  1  requester B (load writeback) has a write pending.
REQ-009 b_ready  output  1  requester B write accepted this cycle.
REQ-010 b_addr  input  5  requester B destination register.
REQ-011 b_data  input  32  requester B write data.
REQ-012 WE3  output  1  register-file write enable, registered.
REQ-013 WA3  output  5  register-file write address, registered.
REQ-014 WD3  output  32  register-file write data, registered.
REQ-015 busy  output  1  high while the clear sequence runs.
REQ-016 grant_id  output  1  requester whose write drives WE3/WA3/WD3 this cycle: 0 = A, 1 = B, 0 during clear.

Function
REQ-017 The block SHALL have two states: CLEAR and RUN.
REQ-018 CLEAR SHALL hold a 5-bit counter cnt, which starts at 1.
REQ-019 On each edge in CLEAR, the block SHALL register WE3=1, WA3=cnt and WD3=0, then increment cnt.
REQ-020 The edge that writes cnt=31 SHALL move the state to RUN.
REQ-021 The clear sequence SHALL therefore drive WE3 high for exactly 31 consecutive cycles, with WA3 going 1..31.
REQ-022 busy SHALL be high in CLEAR, with a_ready = b_ready = 0.
REQ-023 With CLR_EN=0, the first edge after reset is released SHALL enter RUN directly, and busy SHALL never assert.
REQ-024 In RUN, a_ready and b_ready SHALL be combinational from the valids and the last-grant pointer.
REQ-025 In RUN, at most one of a_ready and b_ready SHALL be high in any cycle.
REQ-026 Only A valid: a_ready=1. Only B valid: b_ready=1.
REQ-027 Both valid: the requester not granted last (per the pointer) SHALL win; the other SHALL see ready=0 and hold its request.
REQ-028 The last-grant pointer SHALL update to the granted requester on every accepted handshake (valid && ready).
REQ-029 An accepted handshake at edge k SHALL appear on WE3/WA3/WD3 and grant_id in the cycle after edge k (latency 1).
REQ-030 An accepted request with addr=0 SHALL be consumed: ready=1, and the pointer updates.
REQ-031 For an addr=0 request, WE3 SHALL register 0, with WA3=0 and WD3=0.
REQ-032 A cycle with no handshake SHALL register WE3=0; WA3 and WD3 SHALL then register 0.
REQ-033 Equal addresses on A and B in the same cycle are not merged: two writes on consecutive cycles in grant order, the last one persisting.
REQ-034 valid and ready are free of combinational loops: valid SHALL NOT depend on ready.
REQ-035 A requester holding valid while ready=0 SHALL keep addr and data stable; the block samples them only on handshake.

Reset
REQ-036 While reset=1 at an edge: state=CLEAR (CLR_EN=1) or RUN (CLR_EN=0), cnt=1, and the pointer = B, so A wins the first tie.
REQ-037 While reset=1 at an edge, the outputs SHALL be WE3=0, WA3=0, WD3=0 and grant_id=0.
REQ-038 The busy and ready outputs SHALL reflect the reset state: busy=1 with CLR_EN=1, busy=0 with CLR_EN=0.
REQ-039 A reset asserted mid-CLEAR or mid-RUN SHALL abort the current activity, discard any pending grant, and restart from REQ-036 on the next edge.

Verification
REQ-040 Clear sequence: reset 2 cycles, release, CLR_EN=1 -> WE3=1 for 31 cycles with WA3=1,2,...,31 and WD3=0; busy falls after the cnt=31 write; no ready during busy.
REQ-041 Tie arbitration: in RUN, both valid for 4 cycles, a_addr=5/a_data=0xAAAA0000, b_addr=6/b_data=0xBBBB0000 -> grants A,B,A,B; WA3 sequence 5,6,5,6, each one cycle after its handshake.
REQ-042 Single requester: B alone valid 3 cycles, b_addr=7 -> b_ready=1 each cycle, a_ready=0, WE3=1 with WA3=7 for 3 cycles, grant_id=1.
REQ-043 x0 discard: A valid with a_addr=0, a_data=0xFFFFFFFF -> a_ready=1, next cycle WE3=0, WA3=0, WD3=0.
REQ-044 Same-address collision: both valid with addr=9, a_data=1, b_data=2, pointer=B -> writes WD3=1 then WD3=2 to WA3=9; the final regFile value is 2.
REQ-045 Reset mid-clear: assert reset while cnt=12 -> WE3=0 next cycle; after release, the clear restarts at WA3=1 and runs the full 31 cycles.
